syn_hex_led_ctrl: RTL and testbench
===================================

// Module: syn_hex_led_ctrl
// PURPOSE
// - Local-bus slave that drives the DE1 board status outputs: HEX0..HEX3 seven-segment digits, LEDR[9:0] and LEDG[7:0].
// - Sits downstream of the FPGA top's LB fabric on the cortex clock domain.
// - Replaces the hard-tied pin assigns: HEX blank, LEDs zero, LEDR[9:7] showing reset status.
// - Software writes hex nibbles, digit enables and LED patterns. Hardware decodes them, blinks digits and overlays reset-status LEDs.
// PARAMETERS
// - P_LB_DWIDTH    32        local-bus data width (>=16)
// - P_LB_AWIDTH    16        local-bus address width; only addr[2:0] decoded, upper bits must be 0
// - P_BLINK_DIV    25000000  clk cycles per blink half-period (0.5 s at 50 MHz); >=2
// PORTS
// - clk          in   1              cortex clock (50 MHz)
// - rst          in   1              synchronous, active-high reset
// - lb_wr_en     in   1              LB write strobe, 1-cycle pulse
// - lb_rd_en     in   1              LB read strobe, 1-cycle pulse
// - lb_addr      in   P_LB_AWIDTH    LB word address
// - lb_wr_data   in   P_LB_DWIDTH    LB write data
// - lb_rd_data   out  P_LB_DWIDTH    LB read data, qualified by lb_rd_valid
// - lb_rd_valid  out  1              read data valid, 1-cycle pulse
// - rst_status   in   3              {sys_rst_l, cortex_rst_l, fft_cache_rst_l}, already synchronous to clk
// - hex0..hex3   out  7 each         seven-segment, active-low, bit order {g,f,e,d,c,b,a}
// - ledr         out  10             red LEDs, active-high
// - ledg         out  8              green LEDs, active-high
// BEHAVIOUR
// - Reset values:
//   - All registers 0; lb_rd_valid=0; lb_rd_data=0.
//   - hex0..3 = 7'h7F (blank); ledr=0; ledg=0; blink counter=0; blink phase=0.
//   - The first clk after rst deasserts shows the true status overlay on ledr.
// - Register map (addr[2:0]; higher addr bits nonzero = unmapped):
//   - 0 HEX_VAL  RW [15:0]  nibble n -> hex n (hex0 = [3:0])
//   - 1 HEX_CTRL RW [3:0] digit enable; [7:4] blink mask
//   - 2 LEDR     RW [6:0]  drives ledr[6:0]
//   - 3 LEDG     RW [7:0]  drives ledg[7:0]
//   - 4 STATUS   RO [2:0]  = ~rst_status; [15:8] = 8'h5A ID
//   - 5-7        unmapped: writes ignored, reads return 0 with rd_valid
// - Unused register bits read as 0.
// - Write: register updates on the clk edge where lb_wr_en=1; outputs reflect the new value one further cycle later (registered outputs).
// - Read: lb_rd_valid and lb_rd_data are asserted exactly 1 cycle after lb_rd_en; every read completes, no wait states.
// - Simultaneous rd_en+wr_en to the same address: the write commits and the read returns the pre-write value.
// - Decode: 0-F -> 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex).
//   - Disabled digit = 7'h7F.
//   - Blinking digit with phase=1 = 7'h7F.
// - ledr[9:7] = ~rst_status, live and not software-writable (one-cycle output register delay).
// - Blink counter (macro on):
//   - Counts 0..P_BLINK_DIV-1, wraps to 0 and toggles phase on wrap.
//   - Free-running, independent of LB activity; reset mid-count clears counter and phase.
// - Reset asserted during a read: the pending lb_rd_valid is suppressed (forced 0 next cycle).
// CONFIGURATION
// - SYN_HEX_BLINK_EN defined: blink counter, phase and HEX_CTRL[7:4] are implemented as above.
// - Not defined: no counter logic; HEX_CTRL[7:4] writes are ignored and read as 0; enabled digits are always lit.
// TESTING
// - Reset then idle 10 cycles -> hex0..3=7F, ledr[6:0]=0, ledg=0, lb_rd_valid never high.
// - Write HEX_VAL=16'hA5F0, then HEX_CTRL=4'hF -> 2 cycles after the second write: hex0=40, hex1=0E, hex2=12, hex3=08.
// - Write LEDR=7'h55, LEDG=8'hC3, rst_status=3'b101 -> ledr=10'b010_1010101, ledg=C3.
//   - Read addr 4 -> next cycle rd_valid=1, rd_data=32'h00005A02.
// - Same-cycle rd_en+wr_en addr 3, old 8'hC3, new 8'h0F -> rd_data=C3; a following read returns 0F.
//   - Read addr 6 or addr 16'h0100 -> rd_data=0 with rd_valid.
// - SYN_HEX_BLINK_EN with P_BLINK_DIV=4, HEX_CTRL=8'h11 -> hex0 alternates digit/7F every 4 cycles; hex1..3=7F.
//   - rst mid-count -> phase 0 and digit lit 2 cycles after rst release.
// - Macro off, HEX_CTRL write 8'hF1 -> readback 32'h1; hex0 constantly lit.

Source files
------------

// File: rtl/syn_hex_led_ctrl.sv
// Local-bus slave driving the DE1 HEX0..3 digits, LEDR and LEDG with a reset-status overlay.
// Optional digit blinking is compiled in with SYN_HEX_BLINK_EN.
module syn_hex_led_ctrl #(
  parameter int P_LB_DWIDTH = 32,
  parameter int P_LB_AWIDTH = 16,
  parameter int P_BLINK_DIV = 25000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   lb_wr_en,
  input  logic                   lb_rd_en,
  input  logic [P_LB_AWIDTH-1:0] lb_addr,
  input  logic [P_LB_DWIDTH-1:0] lb_wr_data,
  output logic [P_LB_DWIDTH-1:0] lb_rd_data,
  output logic                   lb_rd_valid,
  input  logic [2:0]             rst_status,
  output logic [6:0]             hex0,
  output logic [6:0]             hex1,
  output logic [6:0]             hex2,
  output logic [6:0]             hex3,
  output logic [9:0]             ledr,
  output logic [7:0]             ledg
);

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40; 4'h1: seg7 = 7'h79; 4'h2: seg7 = 7'h24; 4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19; 4'h5: seg7 = 7'h12; 4'h6: seg7 = 7'h02; 4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00; 4'h9: seg7 = 7'h10; 4'hA: seg7 = 7'h08; 4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46; 4'hD: seg7 = 7'h21; 4'hE: seg7 = 7'h06; default: seg7 = 7'h0E;
    endcase
  endfunction

  logic                   mapped;
  logic [2:0]             a;
  logic [15:0]            hex_val_q, hex_val_d;
  logic [3:0]             en_q, en_d;
  logic [3:0]             mask_q;
  logic [3:0]             blank;
  logic [6:0]             ledr_q, ledr_d;
  logic [7:0]             ledg_q, ledg_d;
  logic [P_LB_DWIDTH-1:0] rd_mux, rd_data_q;
  logic                   rd_valid_q;
  logic [3:0][6:0]        hex_q, hex_d;
  logic [9:0]             ledr_out_q;
  logic [7:0]             ledg_out_q;
  logic                   unused_ok;

  assign unused_ok = ^lb_wr_data;
  assign mapped    = (lb_addr[P_LB_AWIDTH-1:3] == '0);
  assign a         = lb_addr[2:0];

`ifdef SYN_HEX_BLINK_EN
  localparam int CW = $clog2(P_BLINK_DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic [3:0]    mask_d;

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    phase_d = phase_q;
    if (cnt_q == CW'(P_BLINK_DIV - 1)) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      mask_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      mask_q  <= mask_d;
    end
  end

  assign blank = mask_q & {4{phase_q}};
`else
  assign mask_q = '0;
  assign blank  = '0;
`endif

  always_comb begin
    hex_val_d = hex_val_q;
    en_d      = en_q;
    ledr_d    = ledr_q;
    ledg_d    = ledg_q;
`ifdef SYN_HEX_BLINK_EN
    mask_d    = mask_q;
`endif
    if (lb_wr_en && mapped) begin
      case (a)
        3'd0: hex_val_d = lb_wr_data[15:0];
        3'd1: begin
          en_d = lb_wr_data[3:0];
`ifdef SYN_HEX_BLINK_EN
          mask_d = lb_wr_data[7:4];
`endif
        end
        3'd2: ledr_d = lb_wr_data[6:0];
        3'd3: ledg_d = lb_wr_data[7:0];
        default: ;
      endcase
    end
  end

  // Read mux sees current registers, so a same-cycle write returns the old value.
  always_comb begin
    rd_mux = '0;
    if (mapped) begin
      case (a)
        3'd0: rd_mux[15:0] = hex_val_q;
        3'd1: rd_mux[7:0]  = {mask_q, en_q};
        3'd2: rd_mux[6:0]  = ledr_q;
        3'd3: rd_mux[7:0]  = ledg_q;
        3'd4: begin
          rd_mux[2:0]  = ~rst_status;
          rd_mux[15:8] = 8'h5A;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++)
      hex_d[i] = (en_q[i] && !blank[i]) ? seg7(hex_val_q[4*i +: 4]) : 7'h7F;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hex_val_q  <= '0;
      en_q       <= '0;
      ledr_q     <= '0;
      ledg_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      hex_q      <= {4{7'h7F}};
      ledr_out_q <= '0;
      ledg_out_q <= '0;
    end else begin
      hex_val_q  <= hex_val_d;
      en_q       <= en_d;
      ledr_q     <= ledr_d;
      ledg_q     <= ledg_d;
      rd_valid_q <= lb_rd_en;
      rd_data_q  <= lb_rd_en ? rd_mux : '0;
      hex_q      <= hex_d;
      ledr_out_q <= {~rst_status, ledr_q};
      ledg_out_q <= ledg_q;
    end
  end

  assign lb_rd_data  = rd_data_q;
  assign lb_rd_valid = rd_valid_q;
  assign hex0        = hex_q[0];
  assign hex1        = hex_q[1];
  assign hex2        = hex_q[2];
  assign hex3        = hex_q[3];
  assign ledr        = ledr_out_q;
  assign ledg        = ledg_out_q;

endmodule

// File: tb/tb_syn_hex_led_ctrl.sv
// Directed plus randomized bench for syn_hex_led_ctrl against a register-map model.
module tb_syn_hex_led_ctrl;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lb_wr_en = 1'b0, lb_rd_en = 1'b0;
  logic [15:0] lb_addr = '0;
  logic [31:0] lb_wr_data = '0;
  logic [31:0] lb_rd_data;
  logic        lb_rd_valid;
  logic [2:0]  rst_status = 3'b111;
  logic [6:0]  hex0, hex1, hex2, hex3;
  logic [9:0]  ledr;
  logic [7:0]  ledg;

  int vectors = 0, miscompares = 0;
  int ecnt = 0;

  // model state
  logic [15:0] m_val;
  logic [3:0]  m_en, m_mask;
  logic [6:0]  m_ledr;
  logic [7:0]  m_ledg;
  logic [6:0]  seg_tab [16] = '{7'h40,7'h79,7'h24,7'h30,7'h19,7'h12,7'h02,7'h78,
                                7'h00,7'h10,7'h08,7'h03,7'h46,7'h21,7'h06,7'h0E};
`ifdef SYN_HEX_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  syn_hex_led_ctrl #(.P_LB_DWIDTH(32), .P_LB_AWIDTH(16), .P_BLINK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .lb_wr_en(lb_wr_en), .lb_rd_en(lb_rd_en), .lb_addr(lb_addr),
    .lb_wr_data(lb_wr_data), .lb_rd_data(lb_rd_data), .lb_rd_valid(lb_rd_valid),
    .rst_status(rst_status), .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .ledr(ledr), .ledg(ledg));

  always #5 clk = ~clk;

  // edges elapsed since reset release; blink phase follows from it arithmetically
  always @(posedge clk) if (rst) ecnt <= 0; else ecnt <= ecnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic void m_clear();
    m_val = '0; m_en = '0; m_mask = '0; m_ledr = '0; m_ledg = '0;
  endfunction

  function automatic void m_write(input logic [15:0] ad, input logic [31:0] d);
    if (ad[15:3] != 0) return;
    case (ad[2:0])
      3'd0: m_val = d[15:0];
      3'd1: begin m_en = d[3:0]; m_mask = BLINK ? d[7:4] : 4'h0; end
      3'd2: m_ledr = d[6:0];
      3'd3: m_ledg = d[7:0];
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [15:0] ad);
    if (ad[15:3] != 0) return 32'h0;
    case (ad[2:0])
      3'd0: return {16'h0, m_val};
      3'd1: return {24'h0, m_mask, m_en};
      3'd2: return {25'h0, m_ledr};
      3'd3: return {24'h0, m_ledg};
      3'd4: return {16'h0, 8'h5A, 5'h0, ~rst_status};
      default: return 32'h0;
    endcase
  endfunction

  // output after edge k reflects the phase that held after edge k-1
  function automatic logic [6:0] m_hex(input int i);
    logic ph;
    ph = (ecnt >= 1) ? logic'(((ecnt - 1) / DIV) % 2) : 1'b0;
    if (!m_en[i]) return 7'h7F;
    if (BLINK && m_mask[i] && ph) return 7'h7F;
    return seg_tab[m_val[4*i +: 4]];
  endfunction

  task automatic check_all();
    chk("hex0", {25'h0, hex0}, {25'h0, m_hex(0)});
    chk("hex1", {25'h0, hex1}, {25'h0, m_hex(1)});
    chk("hex2", {25'h0, hex2}, {25'h0, m_hex(2)});
    chk("hex3", {25'h0, hex3}, {25'h0, m_hex(3)});
    chk("ledr", {22'h0, ledr}, {22'h0, ~rst_status, m_ledr});
    chk("ledg", {24'h0, ledg}, {24'h0, m_ledg});
    chk("rd_valid_idle", {31'h0, lb_rd_valid}, 32'h0);
  endtask

  task automatic do_wr(input logic [15:0] ad, input logic [31:0] d);
    lb_wr_en = 1'b1; lb_addr = ad; lb_wr_data = d;
    tick();
    lb_wr_en = 1'b0;
    m_write(ad, d);
  endtask

  task automatic do_rd(input logic [15:0] ad);
    logic [31:0] exp;
    exp = m_read(ad);
    lb_rd_en = 1'b1; lb_addr = ad;
    tick();
    lb_rd_en = 1'b0;
    chk("rd_valid", {31'h0, lb_rd_valid}, 32'h1);
    chk("rd_data", lb_rd_data, exp);
  endtask

  initial begin
    logic [31:0] exp;
    logic [15:0] ad;
    m_clear();
    repeat (3) tick();
    chk("rst_hex0", {25'h0, hex0}, 32'h7F);
    chk("rst_rd_valid", {31'h0, lb_rd_valid}, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(); check_all(); end

    do_wr(16'd0, 32'h0000A5F0);
    do_wr(16'd1, 32'h0000000F);
    tick();
    chk("dec_hex0", {25'h0, hex0}, 32'h40);
    chk("dec_hex1", {25'h0, hex1}, 32'h0E);
    chk("dec_hex2", {25'h0, hex2}, 32'h12);
    chk("dec_hex3", {25'h0, hex3}, 32'h08);

    rst_status = 3'b101;
    do_wr(16'd2, 32'h00000055);
    do_wr(16'd3, 32'h000000C3);
    tick();
    chk("ledr_ovl", {22'h0, ledr}, {22'h0, 10'b010_1010101});
    chk("ledg_val", {24'h0, ledg}, 32'hC3);
    do_rd(16'd4);
    chk("status_const", lb_rd_data, 32'h00005A02);

    // read and write to the same register in one cycle
    exp = m_read(16'd3);
    lb_rd_en = 1'b1; lb_wr_en = 1'b1; lb_addr = 16'd3; lb_wr_data = 32'h0000000F;
    tick();
    lb_rd_en = 1'b0; lb_wr_en = 1'b0;
    m_write(16'd3, 32'h0F);
    chk("rw_same_valid", {31'h0, lb_rd_valid}, 32'h1);
    chk("rw_same_old", lb_rd_data, exp);
    chk("rw_same_c3", lb_rd_data, 32'hC3);
    do_rd(16'd3);
    chk("rw_follow_0f", lb_rd_data, 32'h0F);
    do_rd(16'd6);
    do_rd(16'h0100);
    do_wr(16'h0102, 32'hFFFFFFFF);
    tick(); check_all();

    do_wr(16'd1, 32'h000000F1);
    do_rd(16'd1);
    chk("ctrl_readback", lb_rd_data, BLINK ? 32'hF1 : 32'h1);
    do_wr(16'd1, 32'h00000011);
    for (int i = 0; i < 3 * DIV; i++) begin tick(); check_all(); end

    // reset arriving with a read strobe
    lb_rd_en = 1'b1; lb_addr = 16'd4; rst = 1'b1;
    tick();
    lb_rd_en = 1'b0;
    chk("rst_rd_suppress", {31'h0, lb_rd_valid}, 32'h0);
    tick();
    rst = 1'b0;
    m_clear();
    tick(); check_all();
    do_wr(16'd0, 32'h00001234);
    do_wr(16'd1, 32'h00000011);
    for (int i = 0; i < 2 * DIV; i++) begin tick(); check_all(); end

    for (int n = 0; n < 250; n++) begin
      ad = 16'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) ad = ad | 16'h0100;
      case ($urandom_range(0, 3))
        0: begin do_wr(ad, $urandom); tick(); check_all(); end
        1: begin do_rd(ad); tick(); check_all(); end
        2: begin rst_status = 3'($urandom); tick(); check_all(); end
        default: begin tick(); check_all(); end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
